aes_256_stream_ctrl: RTL



---
 rtl/aes_ctrl_pkg.sv | 14 +
 rtl/aes_block_serializer.sv | 46 ++++
 rtl/aes_256_stream_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES-256 stream front-end.
package aes_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE, KEY, DATA, LOAD, WAIT_LOW, WAIT_DONE, CAP, OUT
  } state_t;

  localparam int HDR_ENC     = 0;
  localparam int HDR_REUSE   = 1;
  localparam int KEY_WORDS   = 8;
  localparam int BLK_WORDS   = 4;
  localparam int TIMEOUT_DEF = 127;

endpackage

// File: rtl/aes_block_serializer.sv
// Captures one 128-bit core result and emits it MSW-first as a 4-word valid/ready stream.
module aes_block_serializer #(
  parameter int WORD_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cap,
  input  logic [4*WORD_W-1:0]   din,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [WORD_W-1:0]     m_data,
  output logic                  m_last,
  output logic                  done
);

  localparam int RES_W = 4 * WORD_W;

  logic [RES_W-1:0] res_q;
  logic [1:0]       idx_q;
  logic             vld_q;
  logic             hs;

  assign hs      = vld_q & m_ready;
  assign m_valid = vld_q;
  assign m_data  = res_q[RES_W-1 -: WORD_W];
  assign m_last  = vld_q & (idx_q == 2'd3);
  assign done    = hs & (idx_q == 2'd3);

  // The buffer shifts left on each accepted word so the head word is always on top.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_q <= '0;
      idx_q <= '0;
      vld_q <= 1'b0;
    end else if (cap) begin
      res_q <= din;
      idx_q <= '0;
      vld_q <= 1'b1;
    end else if (hs) begin
      res_q <= {res_q[RES_W-WORD_W-1:0], {WORD_W{1'b0}}};
      idx_q <= idx_q + 2'd1;
      if (idx_q == 2'd3) vld_q <= 1'b0;
    end
  end

endmodule

// File: rtl/aes_256_stream_ctrl.sv
// Stream front-end for the pipelined AES-256 core: word assembly, core handshake with timeout, result serialisation.
module aes_256_stream_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_DEF,
  parameter int WORD_W      = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [WORD_W-1:0]            s_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [WORD_W-1:0]            m_data,
  output logic                         m_last,
  output logic                         core_load,
  output logic                         core_enc_en,
  output logic [BLK_WORDS*WORD_W-1:0]  core_state_in,
  output logic [KEY_WORDS*WORD_W-1:0]  core_key_in,
  input  logic                         core_done,
  input  logic [BLK_WORDS*WORD_W-1:0]  core_out,
  output logic                         busy,
  output logic                         err_timeout,
  output logic                         err_nokey
);

  localparam int KEY_W = KEY_WORDS * WORD_W;
  localparam int BLK_W = BLK_WORDS * WORD_W;
  localparam int TW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [2:0]    KEY_LAST = 3'(KEY_WORDS - 1);
  localparam logic [2:0]    BLK_LAST = 3'(BLK_WORDS - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);

  state_t        state, nxt;
  logic          rdy_en;
  logic          key_valid;
  logic [2:0]    cnt;
  logic [TW-1:0] tcnt;
  logic          hs_in, to_hit, abort, ser_cap, ser_done;

  assign s_ready = rdy_en && (state inside {IDLE, KEY, DATA});
  assign hs_in   = s_valid & s_ready;
  assign busy    = (state != IDLE);
  assign to_hit  = (tcnt == TO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt       = state;
    core_load = 1'b0;
    ser_cap   = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE:      if (hs_in) nxt = s_data[HDR_REUSE] ? DATA : KEY;
      KEY:       if (hs_in && cnt == KEY_LAST) nxt = DATA;
      DATA:      if (hs_in && cnt == BLK_LAST) nxt = LOAD;
      LOAD: begin
        core_load = 1'b1;
        nxt       = WAIT_LOW;
      end
      // done is still high from the previous run for a few cycles after load
      WAIT_LOW: begin
        if (to_hit)          abort = 1'b1;
        else if (!core_done) nxt   = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (core_done)   nxt   = CAP;
        else if (to_hit) abort = 1'b1;
      end
      CAP: begin
        ser_cap = 1'b1;
        nxt     = OUT;
      end
      OUT:       if (ser_done) nxt = IDLE;
      default:   nxt = IDLE;
    endcase
    if (abort) nxt = IDLE;
  end

  // tcnt equals the number of cycles since the load pulse; it is zeroed as LOAD is entered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_en        <= 1'b0;
      key_valid     <= 1'b0;
      cnt           <= '0;
      tcnt          <= '0;
      core_enc_en   <= 1'b0;
      core_key_in   <= '0;
      core_state_in <= '0;
      err_timeout   <= 1'b0;
      err_nokey     <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      case (state)
        IDLE: if (hs_in) begin
          core_enc_en <= s_data[HDR_ENC];
          cnt         <= '0;
          if (s_data[HDR_REUSE] && !key_valid) err_nokey <= 1'b1;
        end
        KEY: if (hs_in) begin
          core_key_in <= {core_key_in[KEY_W-WORD_W-1:0], s_data};
          key_valid   <= (cnt == KEY_LAST);
          cnt         <= (cnt == KEY_LAST) ? 3'd0 : cnt + 3'd1;
        end
        DATA: if (hs_in) begin
          core_state_in <= {core_state_in[BLK_W-WORD_W-1:0], s_data};
          cnt           <= cnt + 3'd1;
          tcnt          <= '0;
        end
        LOAD, WAIT_LOW, WAIT_DONE: begin
          tcnt <= tcnt + 1'b1;
          if (abort) err_timeout <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  aes_block_serializer #(.WORD_W(WORD_W)) u_ser (
    .clk     (clk),
    .rst     (rst),
    .cap     (ser_cap),
    .din     (core_out),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last),
    .done    (ser_done)
  );

endmodule
